uart_rx_buffer: RTL and testbench

UART_RX_BUFFER -- requirements
Module: uart_rx_buffer

---
 rtl/uart_pkg.sv | 27 ++
 rtl/byte_fifo.sv | 79 +++++++
 rtl/uart_rx_buffer.sv | 132 +++++++++++++
 tb/tb_uart_rx_buffer.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared constants and types for the UART receive path.
//   CLK_FREQ    : system clock frequency in Hz
//   BAUDRATE    : serial line rate in baud
//   BAUDDELAY   : clock cycles per bit period
//   byte_t      : one received character
//   tmo_state_e : states of the receive-buffer idle timeout FSM
// -----------------------------------------------------------------------------
package uart_pkg;

    localparam int CLK_FREQ  = 100000000;
    localparam int BAUDRATE  = 115200;
    localparam int BAUDDELAY = CLK_FREQ / BAUDRATE;

    typedef logic [7:0] byte_t;

    // T_EMPTY  : buffer empty, idle counter parked at 0
    // T_COUNT  : data waiting, counting idle cycles
    // T_EXPIRED: timeout already signalled, waiting for activity
    typedef enum logic [1:0] {
        T_EMPTY   = 2'd0,
        T_COUNT   = 2'd1,
        T_EXPIRED = 2'd2
    } tmo_state_e;

endpackage

// File: rtl/byte_fifo.sv
// -----------------------------------------------------------------------------
// byte_fifo
// Byte-wide FIFO with show-ahead output. Data written on one edge is visible
// on data_o from the following cycle; there is no same-cycle fall-through.
// Ports:
//   clk_i, rst_i   : clock, asynchronous active-high reset (pointers/count only)
//   push_i, data_i : write request and byte
//   pop_i          : read request (removes the byte currently on data_o)
//   data_o         : head byte, 8'h00 while empty
//   empty_o/full_o : occupancy status
//   count_o        : number of bytes stored (0..DEPTH)
// -----------------------------------------------------------------------------
module byte_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  byte_t                    data_i,
    input  logic                     pop_i,
    output byte_t                    data_o,
    output logic                     empty_o,
    output logic                     full_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    byte_t           mem [DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q,  count_d;
    logic            push_ok, pop_ok;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CW'(DEPTH));

    // Guard against callers violating occupancy so count can never leave 0..DEPTH.
    assign pop_ok  = pop_i  && !empty_o;
    assign push_ok = push_i && (!full_o || pop_ok);

    // Power-of-two depth: pointers wrap naturally modulo DEPTH.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is deliberately not reset; the pointers alone define validity.
    always_ff @(posedge clk_i) begin
        if (push_ok) mem[wr_ptr_q] <= data_i;
    end

    assign data_o  = empty_o ? 8'h00 : mem[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/uart_rx_buffer.sv
// -----------------------------------------------------------------------------
// uart_rx_buffer
// Receive buffer between a UART receiver and a byte consumer. Buffers good
// bytes, tracks sticky overrun/framing errors and pulses timeout_o once when
// data has been sitting untouched for TIMEOUT_CYCLES cycles.
// Ports:
//   clk_i, rst_i          : clock, asynchronous active-high reset
//   rx_data_i/rx_valid_i  : byte strobe from the receiver
//   rx_frame_err_i        : bad stop bit strobe (byte is discarded)
//   data_o/valid_o/ready_i: consumer handshake, data_o = 8'h00 when invalid
//   count_o               : bytes stored
//   overrun_o, frame_err_o: sticky error flags, cleared by clr_err_i
//   timeout_o             : one-cycle idle-timeout pulse
// -----------------------------------------------------------------------------
module uart_rx_buffer
    import uart_pkg::*;
#(
    parameter int DEPTH          = 16,
    parameter int TIMEOUT_CYCLES = 34720
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [7:0]               rx_data_i,
    input  logic                     rx_valid_i,
    input  logic                     rx_frame_err_i,
    output logic [7:0]               data_o,
    output logic                     valid_o,
    input  logic                     ready_i,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     overrun_o,
    output logic                     frame_err_o,
    input  logic                     clr_err_i,
    output logic                     timeout_o
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;

    logic            push, pop, activity, nonempty_next;
    logic            empty, full;
    logic [CW-1:0]   count;
    logic            overrun_q, overrun_d;
    logic            frame_err_q, frame_err_d;
    logic            timeout_q, timeout_d;
    tmo_state_e      state_q, state_d;
    logic [TW-1:0]   tmr_q, tmr_d;

    assign pop      = !empty && ready_i;
    assign push     = rx_valid_i && !rx_frame_err_i && (!full || pop);
    assign activity = push || pop;

    // Occupancy after this edge; a pop of the last byte with no push empties it.
    assign nonempty_next = push || (count > CW'(1)) || ((count == CW'(1)) && !pop);

    byte_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (push),
        .data_i  (rx_data_i),
        .pop_i   (pop),
        .data_o  (data_o),
        .empty_o (empty),
        .full_o  (full),
        .count_o (count)
    );

    // A new error in the same cycle as clr_err_i keeps the flag set.
    always_comb begin
        overrun_d   = (overrun_q   && !clr_err_i) || (rx_valid_i && !rx_frame_err_i && full && !pop);
        frame_err_d = (frame_err_q && !clr_err_i) || rx_frame_err_i;
    end

    always_comb begin
        state_d   = state_q;
        tmr_d     = tmr_q;
        timeout_d = 1'b0;
        if (!nonempty_next) begin
            state_d = T_EMPTY;
            tmr_d   = '0;
        end else begin
            case (state_q)
                T_EMPTY: begin
                    state_d = T_COUNT;
                    tmr_d   = '0;
                end
                T_COUNT: begin
                    if (activity) begin
                        tmr_d = '0;
                    end else if (tmr_q == TW'(TIMEOUT_CYCLES - 1)) begin
                        timeout_d = 1'b1;
                        state_d   = T_EXPIRED;
                    end else begin
                        tmr_d = tmr_q + TW'(1);
                    end
                end
                T_EXPIRED: begin
                    if (activity) begin
                        state_d = T_COUNT;
                        tmr_d   = '0;
                    end
                end
                default: begin
                    state_d = T_EMPTY;
                    tmr_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
            timeout_q   <= 1'b0;
            state_q     <= T_EMPTY;
            tmr_q       <= '0;
        end else begin
            overrun_q   <= overrun_d;
            frame_err_q <= frame_err_d;
            timeout_q   <= timeout_d;
            state_q     <= state_d;
            tmr_q       <= tmr_d;
        end
    end

    assign valid_o     = !empty;
    assign count_o     = count;
    assign overrun_o   = overrun_q;
    assign frame_err_o = frame_err_q;
    assign timeout_o   = timeout_q;

endmodule

// File: tb/tb_uart_rx_buffer.sv
module tb_uart_rx_buffer;

    localparam int DEPTH = 16;
    localparam int TMO   = 40;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [7:0]  rx_data_i;
    logic        rx_valid_i;
    logic        rx_frame_err_i;
    logic [7:0]  data_o;
    logic        valid_o;
    logic        ready_i;
    logic [4:0]  count_o;
    logic        overrun_o;
    logic        frame_err_o;
    logic        clr_err_i;
    logic        timeout_o;

    int compared   = 0;
    int mismatched = 0;

    // Reference model: a queue of bytes plus flag bits and an idle-cycle tally.
    logic [7:0] mq[$];
    logic       m_ovr, m_fe;
    int         m_idle;

    always #5 clk_i = ~clk_i;

    uart_rx_buffer #(.DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .rx_data_i      (rx_data_i),
        .rx_valid_i     (rx_valid_i),
        .rx_frame_err_i (rx_frame_err_i),
        .data_o         (data_o),
        .valid_o        (valid_o),
        .ready_i        (ready_i),
        .count_o        (count_o),
        .overrun_o      (overrun_o),
        .frame_err_o    (frame_err_o),
        .clr_err_i      (clr_err_i),
        .timeout_o      (timeout_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_ovr  = 1'b0;
        m_fe   = 1'b0;
        m_idle = 0;
    endtask

    // One clock of stimulus; model advances on the edge, outputs checked 1 ns later.
    task automatic step(input logic v, input logic [7:0] d, input logic fe,
                        input logic rdy, input logic clr);
        bit pop, push, ovr_set;
        logic [7:0] hd;
        rx_valid_i     = v;
        rx_data_i      = d;
        rx_frame_err_i = fe;
        ready_i        = rdy;
        clr_err_i      = clr;
        pop     = (mq.size() > 0) && rdy;
        push    = v && !fe && ((mq.size() < DEPTH) || pop);
        ovr_set = v && !fe && (mq.size() == DEPTH) && !pop;
        @(posedge clk_i);
        if (pop)  void'(mq.pop_front());
        if (push) mq.push_back(d);
        m_ovr = (m_ovr && !clr) || ovr_set;
        m_fe  = (m_fe  && !clr) || fe;
        if (push || pop)        m_idle = 0;
        else if (mq.size() > 0) m_idle++;
        if (mq.size() == 0)     m_idle = 0;
        #1;
        hd = (mq.size() > 0) ? mq[0] : 8'h00;
        chk("count",     32'(count_o),     32'(mq.size()));
        chk("valid",     32'(valid_o),     32'(mq.size() > 0));
        chk("data",      32'(data_o),      32'(hd));
        chk("overrun",   32'(overrun_o),   32'(m_ovr));
        chk("frame_err", 32'(frame_err_o), 32'(m_fe));
        chk("timeout",   32'(timeout_o),   32'((mq.size() > 0) && (m_idle == TMO)));
    endtask

    task automatic idle(input int n, input logic rdy);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0, rdy, 1'b0);
    endtask

    initial begin
        int pulses, pulse_at, pv, pr;
        rst_i = 1'b1; rx_data_i = '0; rx_valid_i = 0; rx_frame_err_i = 0;
        ready_i = 0; clr_err_i = 0;
        model_reset();
        #1;
        chk("rst_count", 32'(count_o), 32'd0);
        chk("rst_valid", 32'(valid_o), 32'd0);
        chk("rst_data",  32'(data_o),  32'd0);
        chk("rst_flags", 32'({overrun_o, frame_err_o, timeout_o}), 32'd0);
        repeat (2) @(posedge clk_i);
        #1 rst_i = 1'b0;

        // Single byte in, visible next cycle, then popped.
        step(1'b1, 8'h56, 1'b0, 1'b1, 1'b0);
        chk("push56_data", 32'(data_o), 32'h56);
        chk("push56_cnt",  32'(count_o), 32'd1);
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        chk("pop56_valid", 32'(valid_o), 32'd0);

        // Fill past capacity, then push-and-pop while full.
        for (int i = 0; i <= 16; i++) step(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
        chk("full_cnt", 32'(count_o), 32'd16);
        chk("full_ovr", 32'(overrun_o), 32'd1);
        step(1'b1, 8'hAA, 1'b0, 1'b1, 1'b0);
        chk("full_pp_cnt", 32'(count_o), 32'd16);
        for (int i = 0; i < 16; i++) step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        chk("clr_ovr", 32'(overrun_o), 32'd0);

        // Byte with framing error is discarded; flag then cleared.
        step(1'b1, 8'h33, 1'b1, 1'b0, 1'b0);
        chk("fe_cnt", 32'(count_o), 32'd0);
        chk("fe_flag", 32'(frame_err_o), 32'd1);
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
        chk("fe_clr_wins", 32'(frame_err_o), 32'd1);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        chk("fe_clr", 32'(frame_err_o), 32'd0);

        // Idle timeout: exactly one pulse, TMO cycles after data became visible.
        step(1'b1, 8'h5A, 1'b0, 1'b0, 1'b0);
        pulses = 0; pulse_at = -1;
        for (int i = 1; i <= TMO + 20; i++) begin
            step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
            if (timeout_o) begin pulses++; pulse_at = i; end
        end
        chk("tmo_pulses", 32'(pulses), 32'd1);
        chk("tmo_pos", 32'(pulse_at), 32'(TMO));

        // Asynchronous reset with 5 bytes stored.
        for (int i = 0; i < 4; i++) step(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0, 1'b0);
        chk("pre_rst_cnt", 32'(count_o), 32'd5);
        rst_i = 1'b1;
        #1;
        chk("arst_count", 32'(count_o), 32'd0);
        chk("arst_valid", 32'(valid_o), 32'd0);
        chk("arst_data",  32'(data_o),  32'd0);
        chk("arst_flags", 32'({overrun_o, frame_err_o, timeout_o}), 32'd0);
        model_reset();
        @(posedge clk_i);
        #2 rst_i = 1'b0;
        step(1'b1, 8'h77, 1'b0, 1'b0, 1'b0);
        chk("post_rst_cnt", 32'(count_o), 32'd1);

        // Randomized traffic in phases of varying push/pop density.
        for (int ph = 0; ph < 16; ph++) begin
            pv = $urandom_range(0, 3) == 0 ? 0 : $urandom_range(10, 90);
            pr = $urandom_range(0, 3) == 0 ? 0 : $urandom_range(10, 90);
            for (int i = 0; i < 60; i++)
                step($urandom_range(0, 99) < pv, 8'($urandom), $urandom_range(0, 99) < 5,
                     $urandom_range(0, 99) < pr, $urandom_range(0, 99) < 5);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
